machine_timer: RTL

- Memory-mapped machine timer, the producer side of the CPU's timer-interrupt path.
- Owns free-running counters: cycle, time, and writable mtime/mtimecmp.
- Drives the counter buses consumed by the CSR stage, which compares mtime against mtimecmp to raise the timer trap.
- Software reaches mtime/mtimecmp through a simple memory request/response port decoded by the memory arbiter.

---
 rtl/machine_timer_pkg.sv | 17 +
 rtl/tick_prescaler.sv | 28 ++
 rtl/machine_timer.sv | 117 +++++++++++
 3 files changed

// File: rtl/machine_timer_pkg.sv
// Shared register offsets, FSM encoding and reset constants for the machine timer.
// Pure definitions: no latency or backpressure of its own.
package machine_timer_pkg;

    localparam logic [3:0] MTIMER_OFF_MTIME_LO    = 4'h0;
    localparam logic [3:0] MTIMER_OFF_MTIME_HI    = 4'h4;
    localparam logic [3:0] MTIMER_OFF_MTIMECMP_LO = 4'h8;
    localparam logic [3:0] MTIMER_OFF_MTIMECMP_HI = 4'hC;

    localparam logic [63:0] MTIMECMP_RESET = 64'hffff_ffff_ffff_ffff;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } mtimer_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the core clock by FMAX_MHz to produce a one-cycle 1 us tick.
// Tick is combinational from the count register; no backpressure.
module tick_prescaler #(
    parameter int FMAX_MHz = 27
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int             CW   = (FMAX_MHz > 1) ? $clog2(FMAX_MHz) : 1;
    localparam logic [CW-1:0]  LAST = CW'(FMAX_MHz - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped cycle/time/mtime/mtimecmp counters plus registered timer-interrupt pending.
// Writes apply at the accept edge; reads respond one cycle later and stall the port for that cycle.
module machine_timer
    import machine_timer_pkg::*;
#(
    parameter int          FMAX_MHz  = 27,
    parameter logic [31:0] BASE_ADDR = 32'hf000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_cmd_start,
    input  logic        mem_cmd_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_cmd_ready,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic [63:0] reg_cycle,
    output logic [63:0] reg_time,
    output logic [63:0] reg_mtime,
    output logic [63:0] reg_mtimecmp,
    output logic        timer_irq_pending
);

    mtimer_state_t state;
    logic          tick;
    logic          accept;
    logic          hit;
    logic          wr_en;
    logic          rd_en;
    logic [3:0]    off;
    logic [63:0]   mtime_inc;
    logic [63:0]   mtime_nxt;
    logic [63:0]   mtimecmp_nxt;
    logic [31:0]   rd_val;

    tick_prescaler #(
        .FMAX_MHz (FMAX_MHz)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // The window is 16-byte aligned, so the upper address bits select it and
    // the low two bits must be zero for a word access.
    assign hit    = (mem_addr[31:4] == BASE_ADDR[31:4]) && (mem_addr[1:0] == 2'b00);
    assign off    = mem_addr[3:0];
    assign accept = mem_cmd_start && (state == IDLE);
    assign wr_en  = accept && mem_cmd_write && hit;
    assign rd_en  = accept && !mem_cmd_write;

    assign mtime_inc = reg_mtime + {63'd0, tick};

    // A half-word write overrides only its half; the other half keeps the
    // ticked value so a carry out of the old low word still lands in hi.
    always_comb begin
        mtime_nxt    = mtime_inc;
        mtimecmp_nxt = reg_mtimecmp;
        rd_val       = 32'd0;
        if (wr_en) begin
            case (off)
                MTIMER_OFF_MTIME_LO:    mtime_nxt[31:0]     = mem_wdata;
                MTIMER_OFF_MTIME_HI:    mtime_nxt[63:32]    = mem_wdata;
                MTIMER_OFF_MTIMECMP_LO: mtimecmp_nxt[31:0]  = mem_wdata;
                MTIMER_OFF_MTIMECMP_HI: mtimecmp_nxt[63:32] = mem_wdata;
                default: ;
            endcase
        end
        if (hit) begin
            case (off)
                MTIMER_OFF_MTIME_LO:    rd_val = reg_mtime[31:0];
                MTIMER_OFF_MTIME_HI:    rd_val = reg_mtime[63:32];
                MTIMER_OFF_MTIMECMP_LO: rd_val = reg_mtimecmp[31:0];
                MTIMER_OFF_MTIMECMP_HI: rd_val = reg_mtimecmp[63:32];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_cycle         <= 64'd0;
            reg_time          <= 64'd0;
            reg_mtime         <= 64'd0;
            reg_mtimecmp      <= MTIMECMP_RESET;
            timer_irq_pending <= 1'b0;
        end else begin
            reg_cycle         <= reg_cycle + 64'd1;
            reg_time          <= reg_time + {63'd0, tick};
            reg_mtime         <= mtime_nxt;
            reg_mtimecmp      <= mtimecmp_nxt;
            timer_irq_pending <= (reg_mtime >= reg_mtimecmp);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mem_cmd_ready <= 1'b1;
            mem_rvalid    <= 1'b0;
            mem_rdata     <= 32'd0;
        end else if (state == IDLE) begin
            if (rd_en) begin
                state         <= RESP;
                mem_cmd_ready <= 1'b0;
                mem_rvalid    <= 1'b1;
                mem_rdata     <= rd_val;
            end
        end else begin
            state         <= IDLE;
            mem_cmd_ready <= 1'b1;
            mem_rvalid    <= 1'b0;
        end
    end

endmodule
